// File: rtl/ddr_arb_pkg.sv
// Shared types and default sizing for the two-requester DDR native-port arbiter.
package ddr_arb_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 128;
  localparam int unsigned DEF_ADDR_WIDTH = 32;
  localparam int unsigned DEF_TIMEOUT    = 1024;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    WR_WAIT,
    RD_ISSUE,
    RD_WAIT
  } state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin picker: on a tie the requester not granted last time wins.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  always_comb begin
    grant = 1'b0;
    if (&req) begin
      grant = ~last;
    end else begin
      grant = req[1];
    end
  end

endmodule

// File: rtl/ddr_native_arbiter.sv
// Arbitrates two command requesters onto a DDR controller native port,
// one transaction outstanding, with a per-transaction completion watchdog.
module ddr_native_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                req_valid,
  input  logic [1:0]                req_we,
  input  logic [2*ADDR_WIDTH-1:0]   req_addr,
  input  logic [2*DATA_WIDTH-1:0]   req_wdata,
  input  logic [2*DATA_WIDTH/8-1:0] req_wmask,
  output logic [1:0]                req_ready,
  output logic [1:0]                rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_err,
  output logic                      timeout_err,
  input  logic                      wr_busy,
  output logic [ADDR_WIDTH-1:0]     wr_addr,
  output logic                      wr_addr_en,
  output logic                      wr_en,
  output logic [DATA_WIDTH-1:0]     wr_data,
  output logic [DATA_WIDTH/8-1:0]   wr_datamask,
  input  logic                      wr_ack,
  input  logic                      rd_busy,
  output logic [ADDR_WIDTH-1:0]     rd_addr,
  output logic                      rd_addr_en,
  output logic                      rd_en,
  input  logic [DATA_WIDTH-1:0]     rd_data,
  input  logic                      rd_valid
);

  localparam int unsigned MW = DATA_WIDTH / 8;

  state_t                state_q, state_d;
  logic                  last_q, last_d;
  logic                  grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [MW-1:0]         wmask_q, wmask_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [1:0]            rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  terr_q, terr_d;
  logic                  pick;

  rr_arbiter_2 u_rr (
    .req   (req_valid),
    .last  (last_q),
    .grant (pick)
  );

  // The watchdog fires on the TIMEOUT-th wait cycle; an ack in that same cycle takes priority.
  logic wd_fire;
  assign wd_fire = (TIMEOUT != 0) && (cnt_q == TIMEOUT - 1);

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    cnt_d       = cnt_q;
    rsp_valid_d = '0;
    rsp_err_d   = 1'b0;
    rdata_d     = rdata_q;
    terr_d      = terr_q;
    req_ready   = '0;
    wr_en       = 1'b0;
    wr_addr_en  = 1'b0;
    rd_en       = 1'b0;
    rd_addr_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_n && (|req_valid)) begin
          req_ready[pick] = 1'b1;
          grant_d = pick;
          last_d  = pick;
          addr_d  = pick ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
          wdata_d = pick ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
          wmask_d = pick ? req_wmask[2*MW-1:MW] : req_wmask[MW-1:0];
          state_d = req_we[pick] ? WR_ISSUE : RD_ISSUE;
        end
      end
      WR_ISSUE: begin
        if (rst_n && !wr_busy) begin
          wr_en      = 1'b1;
          wr_addr_en = 1'b1;
          cnt_d      = '0;
          state_d    = WR_WAIT;
        end
      end
      RD_ISSUE: begin
        if (rst_n && !rd_busy) begin
          rd_en      = 1'b1;
          rd_addr_en = 1'b1;
          cnt_d      = '0;
          state_d    = RD_WAIT;
        end
      end
      WR_WAIT: begin
        if (wr_ack) begin
          rsp_valid_d[grant_q] = 1'b1;
          state_d = IDLE;
        end else if (wd_fire) begin
          rsp_valid_d[grant_q] = 1'b1;
          rsp_err_d = 1'b1;
          terr_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RD_WAIT: begin
        if (rd_valid) begin
          rsp_valid_d[grant_q] = 1'b1;
          rdata_d = rd_data;
          state_d = IDLE;
        end else if (wd_fire) begin
          rsp_valid_d[grant_q] = 1'b1;
          rsp_err_d = 1'b1;
          terr_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      grant_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= '0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rdata_q     <= rdata_d;
      terr_q      <= terr_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_rdata   = rdata_q;
  assign timeout_err = terr_q;
  assign wr_addr     = addr_q;
  assign rd_addr     = addr_q;
  assign wr_data     = wdata_q;
  assign wr_datamask = wmask_q;

endmodule

// File: tb/tb_ddr_native_arbiter.sv
// Self-checking bench for ddr_native_arbiter with a transaction-level reference model.
module tb_ddr_native_arbiter;

  localparam int unsigned DW = 128;
  localparam int unsigned AW = 32;
  localparam int unsigned MW = DW / 8;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req_valid, req_we, req_ready, rsp_valid;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [2*MW-1:0] req_wmask;
  logic [DW-1:0]   rsp_rdata, wr_data, rd_data;
  logic            rsp_err, timeout_err;
  logic            wr_busy, wr_addr_en, wr_en, wr_ack;
  logic            rd_busy, rd_addr_en, rd_en, rd_valid;
  logic [AW-1:0]   wr_addr, rd_addr;
  logic [MW-1:0]   wr_datamask;

  int checks = 0;
  int errors = 0;

  // Reference model state: last granted requester, sticky timeout flag, last read data.
  int            last_m  = 1;
  bit            terr_m  = 1'b0;
  logic [DW-1:0] rdata_m = '0;

  ddr_native_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .timeout_err(timeout_err),
    .wr_busy(wr_busy), .wr_addr(wr_addr), .wr_addr_en(wr_addr_en), .wr_en(wr_en),
    .wr_data(wr_data), .wr_datamask(wr_datamask), .wr_ack(wr_ack),
    .rd_busy(rd_busy), .rd_addr(rd_addr), .rd_addr_en(rd_addr_en), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rsp_valid"}, rsp_valid, '0);
    chk({tag, "_rsp_err"}, rsp_err, '0);
    chk({tag, "_timeout_err"}, timeout_err, '0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, '0);
    chk({tag, "_ready"}, req_ready, '0);
    chk({tag, "_strobes"}, {wr_en, wr_addr_en, rd_en, rd_addr_en}, '0);
    chk({tag, "_addr"}, {wr_addr, rd_addr}, '0);
  endtask

  // One full transaction; entered and left just after a falling edge.
  // ackdly: wait cycle (1-based) in which the ack arrives; 0 means never.
  task automatic run_txn(input logic [1:0] vmask, input logic [1:0] we,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                         input logic [MW-1:0] m0, input logic [MW-1:0] m1,
                         input int busy, input int ackdly, input logic [DW-1:0] rdat);
    int w, waits;
    bit wwe, err;
    w = (vmask == 2'b11) ? 1 - last_m : (vmask[1] ? 1 : 0);
    last_m = w;
    wwe = we[w];
    err = (ackdly == 0) || (ackdly > TO);
    waits = err ? TO : ackdly;

    req_valid = vmask; req_we = we;
    req_addr = {a1, a0}; req_wdata = {d1, d0}; req_wmask = {m1, m0};
    if (wwe) wr_busy = (busy > 0); else rd_busy = (busy > 0);
    #1 chk("ready_grant", req_ready, DW'(1) << w);
    @(negedge clk);
    req_valid = '0;
    for (int i = 0; i < busy; i++) begin
      #1 chk("busy_hold", {wr_en, rd_en, req_ready}, '0);
      @(negedge clk);
      if (i == busy - 1) begin wr_busy = 1'b0; rd_busy = 1'b0; end
    end
    #1 chk("issue_strobes", {wr_en, wr_addr_en, rd_en, rd_addr_en}, wwe ? 4'b1100 : 4'b0011);
    if (wwe) begin
      chk("wr_addr", wr_addr, w ? a1 : a0);
      chk("wr_data", wr_data, w ? d1 : d0);
      chk("wr_mask", wr_datamask, w ? m1 : m0);
    end else begin
      chk("rd_addr", rd_addr, w ? a1 : a0);
    end
    @(negedge clk);
    for (int i = 1; i <= waits; i++) begin
      rd_data = {$urandom, $urandom, $urandom, $urandom};
      if (!err && i == ackdly) begin
        if (wwe) wr_ack = 1'b1;
        else begin rd_valid = 1'b1; rd_data = rdat; end
      end else begin
        // the opposite-direction completion must be ignored while waiting
        if (wwe) rd_valid = 1'b1; else wr_ack = 1'b1;
      end
      #1 chk("wait_quiet", {rsp_valid, wr_en, rd_en, req_ready}, '0);
      @(negedge clk);
      wr_ack = 1'b0; rd_valid = 1'b0;
    end
    if (err) terr_m = 1'b1;
    if (!wwe && !err) rdata_m = rdat;
    chk("rsp_valid", rsp_valid, DW'(1) << w);
    chk("rsp_err", rsp_err, DW'(err));
    chk("timeout_err", timeout_err, DW'(terr_m));
    if (!wwe) chk("rsp_rdata", rsp_rdata, rdata_m);
  endtask

  initial begin
    logic [DW-1:0] a5;
    rst_n = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    wr_busy = 1'b0; wr_ack = 1'b0; rd_busy = 1'b0; rd_valid = 1'b0; rd_data = '0;
    repeat (2) @(negedge clk);
    #1 chk_quiet("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // contention straight after reset: grants alternate 0,1,0,1
    for (int k = 0; k < 4; k++)
      run_txn(2'b11, 2'b11, AW'(32'h1000 + k), AW'(32'h2000 + k),
              DW'(k), DW'(k + 100), '1, '0, 0, 2, '0);

    // single write from requester 0, ack three cycles into the wait
    a5 = {16{8'hA5}};
    run_txn(2'b01, 2'b01, 32'h100, 32'h0, a5, '0, 16'hFFFF, '0, 0, 3, '0);

    // read from requester 1
    run_txn(2'b10, 2'b00, 32'h0, 32'h200, '0, '0, '0, '0, 0, 2, DW'(32'h1234));

    // write backpressure for ten cycles
    run_txn(2'b01, 2'b01, 32'hDEAD_BEE0, 32'h0, DW'(64'h0123_4567_89AB_CDEF), '0,
            16'h0F0F, '0, 10, 1, '0);

    // watchdog expiry, then ack coinciding with the last permitted wait cycle
    run_txn(2'b10, 2'b10, 32'h0, 32'h300, '0, DW'(7), '0, 16'h00FF, 0, 0, '0);
    run_txn(2'b01, 2'b00, 32'h400, 32'h0, '0, '0, '0, '0, 1, TO, DW'(32'hCAFE));

    // completions while idle are ignored
    wr_ack = 1'b1; rd_valid = 1'b1; rd_data = '1;
    @(negedge clk);
    wr_ack = 1'b0; rd_valid = 1'b0;
    #1 chk("idle_ack_ignored", {rsp_valid, rsp_rdata}, {2'b00, rdata_m});

    // randomized traffic against the model
    for (int k = 0; k < 24; k++) begin
      logic [1:0] vm;
      vm = 2'($urandom_range(1, 3));
      run_txn(vm, 2'($urandom), $urandom, $urandom,
              {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
              16'($urandom), 16'($urandom), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 19)), {$urandom, $urandom, $urandom, $urandom});
    end

    // reset abandons an outstanding read; a late rd_valid is ignored
    req_valid = 2'b10; req_we = 2'b00; req_addr = {32'h500, 32'h0};
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1 chk_quiet("mid_reset");
    rst_n = 1'b1;
    rd_valid = 1'b1; rd_data = '1;
    @(negedge clk);
    rd_valid = 1'b0;
    #1 chk("late_rd_valid", {rsp_valid, rsp_rdata}, '0);
    last_m = 1; terr_m = 1'b0; rdata_m = '0;
    run_txn(2'b11, 2'b00, 32'h600, 32'h700, '0, '0, '0, '0, 0, 1, DW'(32'h55));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_native_arbiter.md
DDR_NATIVE_ARBITER -- requirements
Module: ddr_native_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, 128, native data width.
REQ-002 Parameter: ADDR_WIDTH, 32, native address width.
REQ-003 Parameter: TIMEOUT, 1024, watchdog limit in cycles; 0 disables the watchdog.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset.
REQ-005 Port: clk  in  1  sole clock; all logic on its rising edge.
REQ-006 Port: rst_n  in  1  synchronous active-low reset.
REQ-007 Port: req_valid  in  2  per-requester command valid.
REQ-008 Port: req_we  in  2  per-requester direction; 1=write, 0=read.
REQ-009 Port: req_addr  in  2*ADDR_WIDTH  packed addresses; requester i at slice i.
REQ-010 Port: req_wdata  in  2*DATA_WIDTH  packed write data.
REQ-011 Port: req_wmask  in  2*DATA_WIDTH/8  packed write datamask.
REQ-012 Port: req_ready  out  2  command accepted when valid&ready.
REQ-013 Port: rsp_valid  out  2  one-cycle completion pulse per requester.
REQ-014 Port: rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid.
REQ-015 Port: rsp_err  out  1  completion was a timeout, valid with rsp_valid.
REQ-016 Port: timeout_err  out  1  sticky watchdog flag.
REQ-017 Ports to DDR controller: wr_busy in 1; wr_addr out ADDR_WIDTH; wr_addr_en out 1; wr_en out 1; wr_data out DATA_WIDTH; wr_datamask out DATA_WIDTH/8; wr_ack in 1; rd_busy in 1; rd_addr out ADDR_WIDTH; rd_addr_en out 1; rd_en out 1; rd_data in DATA_WIDTH; rd_valid in 1.

Function
REQ-018 The FSM SHALL have states IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT; one transaction outstanding at a time.
REQ-019 In IDLE, req_ready SHALL be high combinationally for exactly the winning requester, and low for both in all other states.
REQ-020 Arbitration SHALL be round-robin: on simultaneous requests the requester not last granted wins; the last-granted pointer updates on every accept.
REQ-021 On accept, addr/data/mask/direction and the grant index SHALL be registered; next state is WR_ISSUE or RD_ISSUE.
REQ-022 WR_ISSUE: while wr_busy=1, the block SHALL wait; on the first cycle with wr_busy=0, it SHALL drive wr_addr_en=wr_en=1 for exactly one cycle with registered wr_addr/wr_data/wr_datamask, then enter WR_WAIT.
REQ-023 RD_ISSUE: the same as REQ-022, using rd_busy, rd_addr_en, rd_en and rd_addr, then enter RD_WAIT.
REQ-024 WR_WAIT: on wr_ack=1, rsp_valid[grant] SHALL pulse the next cycle with rsp_err=0; return to IDLE.
REQ-025 RD_WAIT: on rd_valid=1, rd_data SHALL be captured into rsp_rdata and rsp_valid[grant] SHALL pulse the next cycle; return to IDLE.
REQ-026 Accept-to-issue minimum latency SHALL be 1 cycle; ack-to-rsp latency SHALL be exactly 1 cycle; the next accept is possible in the cycle rsp_valid pulses.
REQ-027 Watchdog: a 32-bit counter SHALL clear on WAIT entry and increment each WAIT cycle; reaching TIMEOUT sets timeout_err and pulses rsp_valid[grant] with rsp_err=1, then IDLE.
REQ-028 If ack/rd_valid and timeout coincide, the ack SHALL win (rsp_err=0).
REQ-029 wr_ack or rd_valid arriving outside the matching WAIT state SHALL be ignored.
REQ-030 rsp_rdata SHALL hold its value until the next read completion; its value on write completions is unspecified.
REQ-031 Addresses SHALL pass through unmodified (no wrap, alignment or range checks).

Reset
REQ-032 When rst_n=0 at a clk edge: state=IDLE, pointer=1 (requester 0 wins the first tie), all outputs 0, timeout_err cleared, rsp_rdata 0.
REQ-033 A reset mid-transaction SHALL abandon the transaction with no rsp_valid; late acks after reset SHALL be ignored per REQ-029.

Structure
REQ-034 Package ddr_arb_pkg SHALL hold the state enum and the DATA_WIDTH/ADDR_WIDTH/TIMEOUT defaults.
REQ-035 The two-way round-robin picker SHALL be sub-module rr_arbiter_2 (inputs: req[1:0], last; output: grant index).

Verification
REQ-036 Single write: req0 we=1 addr=0x100 data=0xA5..A5 mask=0xFFFF; wr_ack after 3 cycles -> one wr_en pulse with those values, then rsp_valid=2'b01 one cycle after ack, rsp_err=0.
REQ-037 Read: req1 addr=0x200, rd_valid with rd_data=0x1234 -> rsp_valid=2'b10 and rsp_rdata=0x1234 one cycle later.
REQ-038 Contention: both valid for 4 transactions -> grants alternate 0,1,0,1 after reset.
REQ-039 Busy backpressure: wr_busy=1 for 10 cycles after accept -> wr_en asserts on the first cycle wr_busy=0, exactly once.
REQ-040 Timeout: TIMEOUT=16, no ack -> rsp_valid with rsp_err=1 after 16 WAIT cycles, timeout_err stays 1; an ack in the same cycle -> rsp_err=0.
REQ-041 Reset in RD_WAIT, then rd_valid -> no rsp_valid; all outputs 0; next request to requester 0 is served.
